// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - four-digit 7-segment scanner sharing one BCDtoSeg decoder
// Snapshots the BCD word per frame, walks the digits with a guard gap, optional leading-zero blanking.
module seg_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic        lz_blank,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [3:0]    CODE_BLANK = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_ON} state_t;
  localparam state_t SLOT_START = (GUARD == 0) ? S_ON : S_GUARD;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [1:0]      idx;
  logic [15:0]     digits_q;
  logic            lzb_q;
  logic            slot_end;
  logic [3:0]      cur_digit;
  logic [3:0]      cur_code;
  logic            lead_blank;

  assign cnt_inc  = cnt + CW'(1);
  assign slot_end = (state != S_IDLE) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The state mirrors where the slot counter will be after this edge.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = SLOT_START;
        default: begin
          if (slot_end) begin
            state_next = SLOT_START;
          end else if (cnt_inc >= CNT_GUARD) begin
            state_next = S_ON;
          end else begin
            state_next = S_GUARD;
          end
        end
      endcase
    end
  end

  // Snapshot only on scan start and at the end of digit 3, so a frame is never torn.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= 2'd0;
      digits_q <= 16'h0000;
      lzb_q    <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (state == S_IDLE) begin
      cnt      <= '0;
      idx      <= 2'd0;
      digits_q <= digits_in;
      lzb_q    <= lz_blank;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        digits_q <= digits_in;
        lzb_q    <= lz_blank;
      end
    end else begin
      cnt <= cnt_inc;
    end
  end

  always_comb begin
    cur_digit  = digits_q[3:0];
    lead_blank = 1'b0;
    case (idx)
      2'd0: begin
        cur_digit  = digits_q[3:0];
        lead_blank = 1'b0;
      end
      2'd1: begin
        cur_digit  = digits_q[7:4];
        lead_blank = lzb_q && (digits_q[15:4] == 12'h000);
      end
      2'd2: begin
        cur_digit  = digits_q[11:8];
        lead_blank = lzb_q && (digits_q[15:8] == 8'h00);
      end
      default: begin
        cur_digit  = digits_q[15:12];
        lead_blank = lzb_q && (digits_q[15:12] == 4'h0);
      end
    endcase
  end

  // Codes A-E have no glyph on this display; 4'hF is kept as the dash.
  assign cur_code = ((cur_digit <= 4'd9) || (cur_digit == 4'hF)) ? cur_digit : CODE_BLANK;

  always_comb begin
    bcd_out    = CODE_BLANK;
    an         = 4'b1111;
    frame_done = 1'b0;
    if (state != S_IDLE) begin
      bcd_out = lead_blank ? CODE_BLANK : cur_code;
      if ((state == S_ON) && !lead_blank) begin
        an = ~(4'b0001 << idx);
      end
      frame_done = (state == S_ON) && (idx == 2'd3) && (cnt == CNT_LAST);
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - directed bench for seg_display_scanner
// Runs with REFRESH_DIV=8, GUARD=2; expected codes and anodes are written out per slot.
module tb_seg_display_scanner;

  localparam int RD = 8;
  localparam int G  = 2;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] digits_in;
  logic        lz_blank;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_display_scanner #(.REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits_in  (digits_in),
    .lz_blank   (lz_blank),
    .bcd_out    (bcd_out),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " idx"}, 16'(digit_idx), 16'd0);
    chk({tag, " bcd"}, 16'(bcd_out), 16'hA);
    chk({tag, " an"},  16'(an), 16'hF);
    chk({tag, " fd"},  16'(frame_done), 16'd0);
  endtask

  // Steps cycles c0..c1 of one slot; anodes are off for the first G cycles.
  task automatic slot(input string tag, input logic [1:0] i, input logic [3:0] b,
                      input logic [3:0] a_on, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s d%0d c%0d idx", tag, i, c), 16'(digit_idx), 16'(i));
      chk($sformatf("%s d%0d c%0d bcd", tag, i, c), 16'(bcd_out), 16'(b));
      chk($sformatf("%s d%0d c%0d an", tag, i, c), 16'(an), (c < G) ? 16'hF : 16'(a_on));
      chk($sformatf("%s d%0d c%0d fd", tag, i, c), 16'(frame_done),
          (i == 2'd3 && c == RD - 1) ? 16'd1 : 16'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    digits_in = 16'h0000;
    lz_blank  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");

    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle_chk("idle_en0");

    // Plain frame 1234
    digits_in = 16'h1234;
    en        = 1'b1;
    slot("f1234", 2'd0, 4'h4, 4'b1110, 0, 7);
    slot("f1234", 2'd1, 4'h3, 4'b1101, 0, 7);
    slot("f1234", 2'd2, 4'h2, 4'b1011, 0, 7);
    slot("f1234", 2'd3, 4'h1, 4'b0111, 0, 7);

    // Leading-zero blanking on 0050
    digits_in = 16'h0050;
    lz_blank  = 1'b1;
    slot("lz0050", 2'd0, 4'h0, 4'b1110, 0, 7);
    slot("lz0050", 2'd1, 4'h5, 4'b1101, 0, 7);
    slot("lz0050", 2'd2, 4'hA, 4'b1111, 0, 7);
    slot("lz0050", 2'd3, 4'hA, 4'b1111, 0, 7);

    lz_blank = 1'b0;
    slot("nolz0050", 2'd0, 4'h0, 4'b1110, 0, 7);
    slot("nolz0050", 2'd1, 4'h5, 4'b1101, 0, 7);
    slot("nolz0050", 2'd2, 4'h0, 4'b1011, 0, 7);
    slot("nolz0050", 2'd3, 4'h0, 4'b0111, 0, 7);

    // All zeros with blanking: only digit 0 lit
    digits_in = 16'h0000;
    lz_blank  = 1'b1;
    slot("lz0000", 2'd0, 4'h0, 4'b1110, 0, 7);
    slot("lz0000", 2'd1, 4'hA, 4'b1111, 0, 7);
    slot("lz0000", 2'd2, 4'hA, 4'b1111, 0, 7);
    slot("lz0000", 2'd3, 4'hA, 4'b1111, 0, 7);

    // Non-decimal codes: B,C map to blank code, F passes as dash
    digits_in = 16'hFCB9;
    lz_blank  = 1'b0;
    slot("fFCB9", 2'd0, 4'h9, 4'b1110, 0, 7);
    slot("fFCB9", 2'd1, 4'hA, 4'b1101, 0, 7);
    slot("fFCB9", 2'd2, 4'hA, 4'b1011, 0, 7);
    slot("fFCB9", 2'd3, 4'hF, 4'b0111, 0, 7);

    // Mid-frame input change must wait for the frame boundary
    digits_in = 16'h1234;
    slot("chg", 2'd0, 4'h4, 4'b1110, 0, 7);
    slot("chg", 2'd1, 4'h3, 4'b1101, 0, 2);
    digits_in = 16'h5678;
    slot("chg", 2'd1, 4'h3, 4'b1101, 3, 7);
    slot("chg", 2'd2, 4'h2, 4'b1011, 0, 7);
    slot("chg", 2'd3, 4'h1, 4'b0111, 0, 7);
    slot("f5678", 2'd0, 4'h8, 4'b1110, 0, 7);
    slot("f5678", 2'd1, 4'h7, 4'b1101, 0, 7);
    slot("f5678", 2'd2, 4'h6, 4'b1011, 0, 4);

    // Drop enable mid-slot of digit 2
    en        = 1'b0;
    digits_in = 16'h4321;
    @(posedge clk);
    @(negedge clk);
    idle_chk("en_drop");
    @(posedge clk);
    @(negedge clk);
    idle_chk("en_low");

    en = 1'b1;
    slot("restart", 2'd0, 4'h1, 4'b1110, 0, 7);
    slot("restart", 2'd1, 4'h2, 4'b1101, 0, 7);
    slot("restart", 2'd2, 4'h3, 4'b1011, 0, 3);

    // Reset with enable still high
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      idle_chk($sformatf("reset_en%0d", k));
    end
    reset = 1'b0;
    slot("post_reset", 2'd0, 4'h1, 4'b1110, 0, 7);
    slot("post_reset", 2'd1, 4'h2, 4'b1101, 0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
